// File: rtl/audio_peak_meter.sv
// audio_peak_meter: windowed peak level meter for a signed PCM stream.
// Three register stages (abs -> window max -> scale/hold) turn each window of
// WINDOW valid samples into a 0..9999 display level, a peak-hold level and a
// full-scale clip flag, all updated together with a one-cycle value_valid.
module audio_peak_meter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned WINDOW       = 4800,
    parameter int unsigned HOLD_WINDOWS = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [15:0]       value,
    output logic [15:0]       hold_value,
    output logic              clip,
    output logic              value_valid
);

    // Magnitude needs one extra bit so the most negative sample is representable.
    localparam int unsigned MAG_W   = DATA_W + 1;
    localparam int unsigned LVL_W   = 16;
    // Product of a MAG_W magnitude and the 14-bit scale constant, never below 32 bits.
    localparam int unsigned PROD_W  = (DATA_W + 15 > 32) ? DATA_W + 15 : 32;
    localparam int unsigned CNT_W   = $clog2(WINDOW);
    localparam int unsigned HOLD_W  = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;
    localparam int unsigned SCALE   = 10000;
    localparam int unsigned MAX_LVL = 9999;

    // Stage A registers
    logic             a_valid;
    logic [MAG_W-1:0] a_mag;
    logic             a_clip;

    // Stage B registers
    logic [MAG_W-1:0] run_max;
    logic             run_clip;
    logic [CNT_W-1:0] cnt;
    logic             b_valid;
    logic [MAG_W-1:0] win_peak;
    logic             win_clip;

    // Stage C / hold registers
    logic [HOLD_W-1:0] hold_cnt;

    // Combinational helpers
    logic [MAG_W-1:0]  sext_c;
    logic [MAG_W-1:0]  mag_c;
    logic              full_scale_c;
    logic [MAG_W-1:0]  peak_c;
    logic              close_c;
    logic [PROD_W-1:0] prod_c;
    logic [PROD_W-1:0] scaled_c;
    logic [LVL_W-1:0]  lvl_c;
    logic              hold_last_c;

    // Absolute value and full-scale detection of the incoming sample
    always_comb begin
        sext_c       = {sample[DATA_W-1], sample};
        mag_c        = sext_c[MAG_W-1] ? (~sext_c + MAG_W'(1)) : sext_c;
        full_scale_c = (sample == {1'b0, {(DATA_W-1){1'b1}}})
                    || (sample == {1'b1, {(DATA_W-1){1'b0}}});
    end

    // Stage A: register magnitude and clip flag of each valid sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid <= 1'b0;
            a_mag   <= '0;
            a_clip  <= 1'b0;
        end else if (clear) begin
            a_valid <= 1'b0;
            a_mag   <= '0;
            a_clip  <= 1'b0;
        end else begin
            a_valid <= sample_valid;
            if (sample_valid) begin
                a_mag  <= mag_c;
                a_clip <= full_scale_c;
            end
        end
    end

    // Running maximum including the current stage-A sample; window close detect
    always_comb begin
        peak_c  = (a_mag > run_max) ? a_mag : run_max;
        close_c = (cnt == CNT_W'(WINDOW - 1));
    end

    // Stage B: accumulate max/clip over WINDOW valid samples, emit on close
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_max  <= '0;
            run_clip <= 1'b0;
            cnt      <= '0;
            b_valid  <= 1'b0;
            win_peak <= '0;
            win_clip <= 1'b0;
        end else if (clear) begin
            run_max  <= '0;
            run_clip <= 1'b0;
            cnt      <= '0;
            b_valid  <= 1'b0;
            win_peak <= '0;
            win_clip <= 1'b0;
        end else begin
            b_valid <= 1'b0;
            if (a_valid) begin
                if (close_c) begin
                    win_peak <= peak_c;
                    win_clip <= run_clip | a_clip;
                    run_max  <= '0;
                    run_clip <= 1'b0;
                    cnt      <= '0;
                    b_valid  <= 1'b1;
                end else begin
                    run_max  <= peak_c;
                    run_clip <= run_clip | a_clip;
                    cnt      <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Scale full-scale magnitude to 0..10000 and saturate to the 4-digit range
    always_comb begin
        prod_c      = PROD_W'(win_peak) * PROD_W'(SCALE);
        scaled_c    = prod_c >> (DATA_W - 1);
        lvl_c       = (scaled_c > PROD_W'(MAX_LVL)) ? LVL_W'(MAX_LVL) : scaled_c[LVL_W-1:0];
        hold_last_c = (hold_cnt == HOLD_W'(HOLD_WINDOWS - 1));
    end

    // Stage C: publish level, clip and peak-hold together with value_valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value       <= '0;
            hold_value  <= '0;
            clip        <= 1'b0;
            value_valid <= 1'b0;
            hold_cnt    <= '0;
        end else if (clear) begin
            value       <= '0;
            hold_value  <= '0;
            clip        <= 1'b0;
            value_valid <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            value_valid <= b_valid;
            if (b_valid) begin
                value <= lvl_c;
                clip  <= win_clip;
                // Hold follows rises at once; decays only after HOLD_WINDOWS lower windows
                if (lvl_c >= hold_value) begin
                    hold_value <= lvl_c;
                    hold_cnt   <= '0;
                end else if (hold_last_c) begin
                    hold_value <= lvl_c;
                    hold_cnt   <= '0;
                end else begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end
        end
    end

endmodule
